// File: rtl/fp_to_int_pipe.sv
// fp_to_int_pipe: parametrised float -> integer converter with classification, rounding and saturation.
// Latency 2 cycles at 1 op/cycle; a stalled output holds both stages and in_ready_o drops once S1 cannot drain.
module fp_to_int_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    parameter int INT_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [EXP_W+MAN_W:0] fp_i,
    input  logic                 signed_i,
    input  logic [1:0]           rm_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [INT_W-1:0]     int_o,
    output logic [2:0]           flag_o
);

    localparam int RW = INT_W + 2;
    localparam logic [EXP_W+1:0] BIAS = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);

    localparam logic [2:0] CLS_NORM = 3'd0;
    localparam logic [2:0] CLS_ZERO = 3'd1;
    localparam logic [2:0] CLS_SUB  = 3'd2;
    localparam logic [2:0] CLS_INF  = 3'd3;
    localparam logic [2:0] CLS_NAN  = 3'd4;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RDN = 2'b10;
    localparam logic [1:0] RM_RUP = 2'b11;

    localparam logic [RW-1:0] MAX_S   = {3'b000, {(INT_W-1){1'b1}}};
    localparam logic [RW-1:0] MIN_MAG = {3'b001, {(INT_W-1){1'b0}}};
    localparam logic [RW-1:0] MAX_U   = {2'b00, {INT_W{1'b1}}};
    localparam logic [INT_W-1:0] POS_MAX_S = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] NEG_MIN_S = {1'b1, {(INT_W-1){1'b0}}};

    logic s1_valid, s2_valid, s1_adv, s2_adv;

    logic                    fp_sign;
    logic [EXP_W-1:0]        fp_exp;
    logic [MAN_W-1:0]        fp_man;
    logic [2:0]              fp_cls;

    logic                    s1_sign;
    logic [2:0]              s1_cls;
    logic signed [EXP_W+1:0] s1_exp;
    logic [MAN_W:0]          s1_sig;
    logic                    s1_signed;
    logic [1:0]              s1_rm;

    int                      e_w, ls, rs;
    logic [INT_W:0]          mag;
    logic [2*MAN_W+2:0]      shifted;
    logic                    guard, sticky, inc, inexact, big, ovf_rng;
    logic [RW-1:0]           rnd;
    logic [INT_W-1:0]        pos_max, neg_min, res;
    logic [2:0]              flg;

    assign s2_adv      = !s2_valid || out_ready_i;
    assign s1_adv      = !s1_valid || s2_adv;
    assign in_ready_o  = s1_adv;
    assign out_valid_o = s2_valid;

    assign fp_sign = fp_i[EXP_W+MAN_W];
    assign fp_exp  = fp_i[EXP_W+MAN_W-1:MAN_W];
    assign fp_man  = fp_i[MAN_W-1:0];

    always_comb begin
        fp_cls = CLS_NORM;
        if (&fp_exp)
            fp_cls = (|fp_man) ? CLS_NAN : CLS_INF;
        else if (!(|fp_exp))
            fp_cls = (|fp_man) ? CLS_SUB : CLS_ZERO;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_cls    <= CLS_ZERO;
            s1_exp    <= '0;
            s1_sig    <= '0;
            s1_signed <= 1'b0;
            s1_rm     <= RM_RNE;
        end else if (s1_adv) begin
            s1_valid <= in_valid_i;
            if (in_valid_i) begin
                s1_sign   <= fp_sign;
                s1_cls    <= fp_cls;
                s1_exp    <= $signed({2'b00, fp_exp} - BIAS);
                s1_sig    <= {1'b1, fp_man};
                s1_signed <= signed_i;
                s1_rm     <= rm_i;
            end
        end
    end

    // Align the significand to the integer point; right shifts keep guard and sticky.
    always_comb begin
        e_w     = int'(s1_exp);
        ls      = e_w - MAN_W;
        rs      = MAN_W - e_w;
        shifted = '0;
        mag     = '0;
        guard   = 1'b0;
        sticky  = 1'b0;
        if (e_w >= MAN_W) begin
            mag = (INT_W+1)'((INT_W+MAN_W+2)'(s1_sig) << ls);
        end else if (rs <= MAN_W + 1) begin
            shifted = {s1_sig, {(MAN_W+2){1'b0}}} >> rs;
            mag     = (INT_W+1)'(shifted[2*MAN_W+2:MAN_W+2]);
            guard   = shifted[MAN_W+1];
            sticky  = |shifted[MAN_W:0];
        end else begin
            sticky  = 1'b1;
        end

        inc = 1'b0;
        case (s1_rm)
            RM_RNE: inc = guard && (sticky || mag[0]);
            RM_RTZ: inc = 1'b0;
            RM_RDN: inc = s1_sign && (guard || sticky);
            RM_RUP: inc = !s1_sign && (guard || sticky);
        endcase
        inexact = guard || sticky;
        rnd     = RW'(mag) + RW'(inc);
        big     = e_w >= INT_W + 1;

        if (s1_signed)
            ovf_rng = s1_sign ? (rnd > MIN_MAG) : (rnd > MAX_S);
        else
            ovf_rng = s1_sign ? (rnd != '0) : (rnd > MAX_U);
    end

    always_comb begin
        pos_max = s1_signed ? POS_MAX_S : '1;
        neg_min = s1_signed ? NEG_MIN_S : '0;
        res     = '0;
        flg     = 3'b000;
        case (s1_cls)
            CLS_ZERO: begin
                res = '0;
                flg = 3'b000;
            end
            CLS_NAN: begin
                res = pos_max;
                flg = 3'b001;
            end
            CLS_INF: begin
                res = s1_sign ? neg_min : pos_max;
                flg = 3'b001;
            end
            CLS_SUB: begin
                if (!s1_sign && s1_rm == RM_RUP) begin
                    res = INT_W'(1);
                    flg = 3'b110;
                end else if (s1_sign && s1_rm == RM_RDN) begin
                    res = s1_signed ? '1 : '0;
                    flg = s1_signed ? 3'b110 : 3'b001;
                end else begin
                    flg = 3'b010;
                end
            end
            default: begin
                if (big || ovf_rng) begin
                    res = s1_sign ? neg_min : pos_max;
                    flg = 3'b001;
                end else begin
                    res = (s1_sign && s1_signed) ? -rnd[INT_W-1:0] : rnd[INT_W-1:0];
                    flg = {inexact, 2'b00};
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s2_valid <= 1'b0;
            int_o    <= '0;
            flag_o   <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                int_o  <= res;
                flag_o <= flg;
            end
        end
    end

endmodule

// File: tb/tb_fp_to_int_pipe.sv
// Scoreboard bench for fp_to_int_pipe: default bf16->int32 instance plus a half->int16 instance.
module tb_fp_to_int_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Default instance
    logic        a_in_valid, a_in_ready, a_signed, a_out_valid, a_out_ready;
    logic [15:0] a_fp;
    logic [1:0]  a_rm;
    logic [31:0] a_int;
    logic [2:0]  a_flag;
    logic [34:0] q_a[$];

    // Half precision to 16-bit instance
    logic        b_in_valid, b_in_ready, b_signed, b_out_valid, b_out_ready;
    logic [15:0] b_fp;
    logic [1:0]  b_rm;
    logic [15:0] b_int;
    logic [2:0]  b_flag;
    logic [18:0] q_b[$];

    fp_to_int_pipe dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .fp_i(a_fp), .signed_i(a_signed), .rm_i(a_rm),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
        .int_o(a_int), .flag_o(a_flag)
    );

    fp_to_int_pipe #(.EXP_W(5), .MAN_W(10), .INT_W(16)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .fp_i(b_fp), .signed_i(b_signed), .rm_i(b_rm),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
        .int_o(b_int), .flag_o(b_flag)
    );

    // {fp, signed, rm, expected int, expected flag}; rm 0 RNE, 1 RTZ, 2 RDN, 3 RUP
    localparam int NA = 29;
    localparam logic [53:0] VA [NA] = '{
        {16'h3FC0, 1'b1, 2'd0, 32'h00000002, 3'b100},
        {16'h3FC0, 1'b1, 2'd1, 32'h00000001, 3'b100},
        {16'hC020, 1'b1, 2'd0, 32'hFFFFFFFE, 3'b100},
        {16'hC020, 1'b1, 2'd2, 32'hFFFFFFFD, 3'b100},
        {16'hC020, 1'b1, 2'd3, 32'hFFFFFFFE, 3'b100},
        {16'h4F00, 1'b1, 2'd0, 32'h7FFFFFFF, 3'b001},
        {16'h4F00, 1'b0, 2'd0, 32'h80000000, 3'b000},
        {16'hCF00, 1'b1, 2'd0, 32'h80000000, 3'b000},
        {16'h7FC0, 1'b0, 2'd0, 32'hFFFFFFFF, 3'b001},
        {16'hFF80, 1'b1, 2'd0, 32'h80000000, 3'b001},
        {16'h7F80, 1'b1, 2'd0, 32'h7FFFFFFF, 3'b001},
        {16'h0000, 1'b1, 2'd0, 32'h00000000, 3'b000},
        {16'h8000, 1'b0, 2'd2, 32'h00000000, 3'b000},
        {16'h0001, 1'b0, 2'd3, 32'h00000001, 3'b110},
        {16'h8001, 1'b1, 2'd2, 32'hFFFFFFFF, 3'b110},
        {16'h8001, 1'b0, 2'd2, 32'h00000000, 3'b001},
        {16'h0001, 1'b1, 2'd0, 32'h00000000, 3'b010},
        {16'hBFC0, 1'b0, 2'd0, 32'h00000000, 3'b001},
        {16'hBE80, 1'b0, 2'd1, 32'h00000000, 3'b100},
        {16'h4F80, 1'b0, 2'd0, 32'hFFFFFFFF, 3'b001},
        {16'h5000, 1'b1, 2'd0, 32'h7FFFFFFF, 3'b001},
        {16'hCF01, 1'b1, 2'd0, 32'h80000000, 3'b001},
        {16'h4EFF, 1'b1, 2'd0, 32'h7F800000, 3'b000},
        {16'h3F00, 1'b1, 2'd0, 32'h00000000, 3'b100},
        {16'h3F00, 1'b1, 2'd3, 32'h00000001, 3'b100},
        {16'h4020, 1'b1, 2'd0, 32'h00000002, 3'b100},
        {16'h4060, 1'b1, 2'd0, 32'h00000004, 3'b100},
        {16'h7F81, 1'b1, 2'd0, 32'h7FFFFFFF, 3'b001},
        {16'hFF80, 1'b0, 2'd0, 32'h00000000, 3'b001}
    };

    localparam int NB = 6;
    localparam logic [37:0] VB [NB] = '{
        {16'h5BD0, 1'b1, 2'd0, 16'h00FA, 3'b000},
        {16'h7800, 1'b1, 2'd0, 16'h7FFF, 3'b001},
        {16'h7800, 1'b0, 2'd0, 16'h8000, 3'b000},
        {16'hFC00, 1'b0, 2'd0, 16'h0000, 3'b001},
        {16'h3C00, 1'b1, 2'd0, 16'h0001, 3'b000},
        {16'hB800, 1'b1, 2'd2, 16'hFFFF, 3'b100}
    };

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Leaves in_valid high after the accepting edge; caller drops it.
    task automatic send_a(input logic [15:0] fp, input logic sg, input logic [1:0] rm,
                          input logic [31:0] ei, input logic [2:0] ef);
        int n = 0;
        @(negedge clk);
        a_in_valid = 1'b1; a_fp = fp; a_signed = sg; a_rm = rm;
        #1;
        while (!a_in_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (!a_in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL a_accept_timeout: in_ready stayed %0b for fp %h", a_in_ready, fp);
            a_in_valid = 1'b0;
        end else begin
            q_a.push_back({ef, ei});
            @(posedge clk);
        end
    endtask

    task automatic send_b(input logic [15:0] fp, input logic sg, input logic [1:0] rm,
                          input logic [15:0] ei, input logic [2:0] ef);
        int n = 0;
        @(negedge clk);
        b_in_valid = 1'b1; b_fp = fp; b_signed = sg; b_rm = rm;
        #1;
        while (!b_in_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (!b_in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL b_accept_timeout: in_ready stayed %0b for fp %h", b_in_ready, fp);
            b_in_valid = 1'b0;
        end else begin
            q_b.push_back({ef, ei});
            @(posedge clk);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 100) begin
            @(negedge clk); n++;
        end
        repeat (4) @(negedge clk);
        chk({name, "_pending_a"}, 64'(q_a.size()), 64'd0);
        chk({name, "_pending_b"}, 64'(q_b.size()), 64'd0);
    endtask

    initial begin : mon_a
        logic        stalled;
        logic [34:0] held, expv;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk); #2;
            if (!rst_n || !a_out_valid) begin
                stalled = 1'b0;
            end else if (!a_out_ready) begin
                if (stalled) begin
                    n_checks++;
                    if ({a_flag, a_int} !== held) begin
                        n_fail++;
                        $display("FAIL a_hold: got %h, held %h", {a_flag, a_int}, held);
                    end
                end
                held    = {a_flag, a_int};
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
                n_checks++;
                if (q_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL a_unexpected: got flag %b int %h, expected nothing", a_flag, a_int);
                end else begin
                    expv = q_a.pop_front();
                    if ({a_flag, a_int} !== expv) begin
                        n_fail++;
                        $display("FAIL a_result: got flag %b int %h, expected flag %b int %h",
                                 a_flag, a_int, expv[34:32], expv[31:0]);
                    end
                end
            end
        end
    end

    initial begin : mon_b
        logic [18:0] expv;
        forever begin
            @(negedge clk); #2;
            if (rst_n && b_out_valid && b_out_ready) begin
                n_checks++;
                if (q_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL b_unexpected: got flag %b int %h, expected nothing", b_flag, b_int);
                end else begin
                    expv = q_b.pop_front();
                    if ({b_flag, b_int} !== expv) begin
                        n_fail++;
                        $display("FAIL b_result: got flag %b int %h, expected flag %b int %h",
                                 b_flag, b_int, expv[18:16], expv[15:0]);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [53:0] va;
        logic [37:0] vb;
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_fp = '0; a_signed = 1'b0; a_rm = 2'd0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_fp = '0; b_signed = 1'b0; b_rm = 2'd0; b_out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk); #2;
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_int", 64'(a_int), 64'd0);
        chk("rst_flag", 64'(a_flag), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);
        rst_n = 1'b1;

        // Latency: 10.0 accepted at one edge, valid after the second edge
        send_a(16'h4120, 1'b1, 2'd0, 32'h0000000A, 3'b000);
        @(negedge clk); a_in_valid = 1'b0; #2;
        chk("lat_after_1", 64'(a_out_valid), 64'd0);
        @(negedge clk); #2;
        chk("lat_after_2", 64'(a_out_valid), 64'd1);
        drain("lat");

        // Directed vectors streamed back to back
        for (int i = 0; i < NA; i++) begin
            va = VA[i];
            send_a(va[53:38], va[37], va[36:35], va[34:3], va[2:0]);
        end
        @(negedge clk); a_in_valid = 1'b0;
        drain("vec");

        // Backpressure: two ops fill the pipe, then in_ready must fall
        @(negedge clk); a_out_ready = 1'b0;
        send_a(16'h4120, 1'b1, 2'd0, 32'h0000000A, 3'b000);
        send_a(16'h3FC0, 1'b1, 2'd0, 32'h00000002, 3'b100);
        @(negedge clk);
        a_fp = 16'hC020; a_signed = 1'b1; a_rm = 2'd2;
        #1;
        chk("bp_in_ready_low", 64'(a_in_ready), 64'd0);
        fork
            begin
                send_a(16'hC020, 1'b1, 2'd2, 32'hFFFFFFFD, 3'b100);
                send_a(16'h4EFF, 1'b1, 2'd0, 32'h7F800000, 3'b000);
                @(negedge clk); a_in_valid = 1'b0;
            end
            begin
                repeat (3) begin
                    @(negedge clk); #1;
                    chk("bp_in_ready_stall", 64'(a_in_ready), 64'd0);
                end
                @(negedge clk); a_out_ready = 1'b1;
            end
        join
        drain("bp");

        // Reset with both stages full discards them
        @(negedge clk); a_out_ready = 1'b0;
        send_a(16'h4F00, 1'b1, 2'd0, 32'h7FFFFFFF, 3'b001);
        send_a(16'hCF00, 1'b1, 2'd0, 32'h80000000, 3'b000);
        @(negedge clk);
        a_in_valid = 1'b0;
        rst_n = 1'b0;
        q_a.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("rst2_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst2_int", 64'(a_int), 64'd0);
        chk("rst2_flag", 64'(a_flag), 64'd0);
        chk("rst2_in_ready", 64'(a_in_ready), 64'd1);
        a_out_ready = 1'b1;
        send_a(16'h4060, 1'b1, 2'd0, 32'h00000004, 3'b100);
        @(negedge clk); a_in_valid = 1'b0;
        drain("rst2");

        // Half-precision to int16 instance
        for (int i = 0; i < NB; i++) begin
            vb = VB[i];
            send_b(vb[37:22], vb[21], vb[20:19], vb[18:3], vb[2:0]);
        end
        @(negedge clk); b_in_valid = 1'b0;
        drain("half");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
